// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin sequencer sharing one single-ported memory between the CPU and the loader port.
// Latency: request sampled in IDLE at edge k -> mem_en in cycle k+1, done in cycle k+2+MEM_LAT, IDLE again at k+3+MEM_LAT.
// Backpressure: level requests wait in place while busy; no loss and no timeout, one access in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // WAIT runs MEM_LAT cycles: counter loads MEM_LAT-1 and ends at zero.
  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);
  localparam logic       SRV_CPU  = 1'b0;
  localparam logic       SRV_LD   = 1'b1;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

  // State, access latch, latency counter and read-data registers; reset forgets any access in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 2'd0;
      last_q      <= SRV_LD;  // CPU wins the first contended grant
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Next-state: arbitrate in IDLE, count latency in WAIT, capture read data on the last WAIT edge.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && (!ld_req || last_q == SRV_LD)) begin
          grant_d = 2'b01;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_ACCESS;
        end else if (ld_req) begin
          grant_d = 2'b10;
          we_d    = ld_we;
          addr_d  = ld_addr;
          wdata_d = ld_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (!we_q) begin
            if (grant_q[0]) cpu_rdata_d = mem_rdata;
            else            ld_rdata_d  = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        last_d  = grant_q[1] ? SRV_LD : SRV_CPU;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registers or the decoded state, never from the request inputs.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = (state_q == S_DONE) & grant_q[0];
  assign ld_done   = (state_q == S_DONE) & grant_q[1];
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Reset;
  // Inputs of the MEM_LAT=1 instance
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [7:0]  cpu_addr, ld_addr;
  logic [31:0] cpu_wdata, ld_wdata, md1;
  // Inputs of the MEM_LAT=3 instance (loader side only)
  logic        l3_req, l3_we;
  logic [7:0]  l3_addr;
  logic [31:0] l3_wdata, md3;

  logic [31:0] d1_cpu_rdata, d1_ld_rdata, d1_mem_wdata;
  logic        d1_cpu_done, d1_ld_done, d1_mem_en, d1_mem_we, d1_busy;
  logic [7:0]  d1_mem_addr;
  logic [1:0]  d1_grant;
  logic [31:0] d3_cpu_rdata, d3_ld_rdata, d3_mem_wdata;
  logic        d3_cpu_done, d3_ld_done, d3_mem_en, d3_mem_we, d3_busy;
  logic [7:0]  d3_mem_addr;
  logic [1:0]  d3_grant;

  logic        vld1;
  logic [2:0]  sh3;
  int          en3_cnt;
  int          checks;
  int          failures;

  // status = {mem_en, mem_we, cpu_done, ld_done, grant[1:0], busy}
  logic [6:0] st1, st3;
  assign st1 = {d1_mem_en, d1_mem_we, d1_cpu_done, d1_ld_done, d1_grant, d1_busy};
  assign st3 = {d3_mem_en, d3_mem_we, d3_cpu_done, d3_ld_done, d3_grant, d3_busy};

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(d1_cpu_rdata), .cpu_done(d1_cpu_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(d1_ld_rdata), .ld_done(d1_ld_done),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(md1),
    .grant(d1_grant), .busy(d1_busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(8'h00), .cpu_wdata(32'h0),
    .cpu_rdata(d3_cpu_rdata), .cpu_done(d3_cpu_done),
    .ld_req(l3_req), .ld_we(l3_we), .ld_addr(l3_addr), .ld_wdata(l3_wdata),
    .ld_rdata(d3_ld_rdata), .ld_done(d3_ld_done),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(md3),
    .grant(d3_grant), .busy(d3_busy)
  );

  always #5 Clk = ~Clk;

  // Memory models: data is only valid exactly MEM_LAT cycles after the mem_en edge.
  always @(posedge Clk) begin
    vld1 <= d1_mem_en;
    sh3  <= {sh3[1:0], d3_mem_en};
    if (d3_mem_en) en3_cnt <= en3_cnt + 1;
  end

  always_comb begin
    md1 = 32'hBAD0BAD0;
    if (vld1) md1 = (d1_mem_addr == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, d1_mem_addr};
    md3 = sh3[2] ? 32'h0BADF00D : 32'hBAD0BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Clk = 1'b0; Reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 32'h0;
    l3_req = 1'b0; l3_we = 1'b0; l3_addr = 8'h00; l3_wdata = 32'h0;
    vld1 = 1'b0; sh3 = 3'b000; en3_cnt = 0;
    checks = 0; failures = 0;

    // Reset held 3 cycles, then idle for 10 cycles
    repeat (3) tick();
    chk("rst_status", 32'(st1), 32'h0);
    chk("rst_cpu_rdata", d1_cpu_rdata, 32'h0);
    chk("rst_mem_addr", 32'(d1_mem_addr), 32'h0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_status", 32'(st1), 32'h0);
      chk("idle_status3", 32'(st3), 32'h0);
    end

    // Single CPU read, MEM_LAT=1
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("rd_access", 32'(st1), 32'h43);
    chk("rd_mem_addr", 32'(d1_mem_addr), 32'h10);
    cpu_addr = 8'h55;  // changing address after grant must not matter
    tick();
    chk("rd_wait", 32'(st1), 32'h03);
    tick();
    chk("rd_done", 32'(st1), 32'h13);
    chk("rd_cpu_rdata", d1_cpu_rdata, 32'hDEADBEEF);
    chk("rd_ld_rdata", d1_ld_rdata, 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("rd_idle", 32'(st1), 32'h0);

    // Loader write, MEM_LAT=3
    l3_req = 1'b1; l3_we = 1'b1; l3_addr = 8'h04; l3_wdata = 32'h12345678;
    tick();
    chk("wr_access", 32'(st3), 32'h65);
    chk("wr_mem_addr", 32'(d3_mem_addr), 32'h04);
    chk("wr_mem_wdata", d3_mem_wdata, 32'h12345678);
    l3_wdata = 32'hFFFFFFFF; l3_addr = 8'hEE;
    tick();
    chk("wr_wait1", 32'(st3), 32'h05);
    chk("wr_wdata_held", d3_mem_wdata, 32'h12345678);
    tick();
    chk("wr_wait2", 32'(st3), 32'h05);
    tick();
    chk("wr_wait3", 32'(st3), 32'h05);
    tick();
    chk("wr_done", 32'(st3), 32'h0D);
    chk("wr_cpu_rdata", d3_cpu_rdata, 32'h0);
    chk("wr_ld_rdata", d3_ld_rdata, 32'h0);
    l3_req = 1'b0;
    tick();
    chk("wr_idle", 32'(st3), 32'h0);
    chk("wr_en_count", 32'(en3_cnt), 32'd1);

    // Contention after reset: CPU, loader, CPU, loader
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h30;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("ct_access", 32'(st1), (r % 2 == 0) ? 32'h43 : 32'h45);
      tick();
      chk("ct_wait", 32'(st1), (r % 2 == 0) ? 32'h03 : 32'h05);
      tick();
      chk("ct_done", 32'(st1), (r % 2 == 0) ? 32'h13 : 32'h0D);
      if (r % 2 == 0) chk("ct_cpu_rdata", d1_cpu_rdata, 32'hC0FFEE20);
      else            chk("ct_ld_rdata", d1_ld_rdata, 32'hC0FFEE30);
      if (r == 3) begin
        cpu_req = 1'b0; ld_req = 1'b0;
      end
      tick();
      chk("ct_idle", 32'(st1), 32'h0);
    end
    tick();
    chk("ct_quiet", 32'(st1), 32'h0);

    // Late loader request during a CPU WAIT
    cpu_req = 1'b1; cpu_addr = 8'h10;
    tick();
    chk("lt_cpu_access", 32'(st1), 32'h43);
    tick();
    chk("lt_cpu_wait", 32'(st1), 32'h03);
    ld_req = 1'b1; ld_addr = 8'h40;
    tick();
    chk("lt_cpu_done", 32'(st1), 32'h13);
    chk("lt_cpu_rdata", d1_cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();
    chk("lt_idle_gap", 32'(st1), 32'h0);
    tick();
    chk("lt_ld_access", 32'(st1), 32'h45);
    chk("lt_ld_addr", 32'(d1_mem_addr), 32'h40);
    tick();
    chk("lt_ld_wait", 32'(st1), 32'h05);
    tick();
    chk("lt_ld_done", 32'(st1), 32'h0D);
    chk("lt_ld_rdata", d1_ld_rdata, 32'hC0FFEE40);
    chk("lt_cpu_kept", d1_cpu_rdata, 32'hDEADBEEF);
    ld_req = 1'b0;
    tick();
    chk("lt_idle", 32'(st1), 32'h0);

    // Reset in the middle of a CPU read
    cpu_req = 1'b1; cpu_addr = 8'h50;
    tick();
    chk("mr_access", 32'(st1), 32'h43);
    tick();
    chk("mr_wait", 32'(st1), 32'h03);
    #2;
    Reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("mr_async_status", 32'(st1), 32'h0);
    chk("mr_async_cpu_rdata", d1_cpu_rdata, 32'h0);
    chk("mr_async_ld_rdata", d1_ld_rdata, 32'h0);
    chk("mr_async_mem_addr", 32'(d1_mem_addr), 32'h0);
    chk("mr_async_mem_wdata", d1_mem_wdata, 32'h0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_done", 32'(st1), 32'h0);
    end
    cpu_req = 1'b1; cpu_addr = 8'h60;
    tick();
    chk("mr_new_access", 32'(st1), 32'h43);
    chk("mr_new_addr", 32'(d1_mem_addr), 32'h60);
    tick();
    chk("mr_new_wait", 32'(st1), 32'h03);
    tick();
    chk("mr_new_done", 32'(st1), 32'h13);
    chk("mr_new_rdata", d1_cpu_rdata, 32'hC0FFEE60);
    cpu_req = 1'b0;
    tick();
    chk("mr_new_idle", 32'(st1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
